// File: rtl/request_queue.sv
// Bounded in-order memory request queue with simulated time base and parser flow control.
// Optional macro REQUEST_QUEUE_TIME_SKIP_EN lets queue_time jump over idle gaps while empty.
package global_defs;
  localparam int ADDRESS_WIDTH = 34;
  typedef logic [31:0] int_t;
  typedef enum logic [1:0] {NOP = 2'd0, READ = 2'd1, WRITE = 2'd2} parsed_op_t;
  typedef struct packed {
    parsed_op_t                 opcode;
    logic [ADDRESS_WIDTH-1:0]   address;
    int_t                       time_cpu;
    logic                       op_ready_s;
  } parser_out_struct_t;
endpackage

module request_queue
  import global_defs::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  parser_out_struct_t         in,
  output int_t                       queue_time,
  output logic                       queue_full,
  output logic                       pending_request,
  output logic                       out_valid,
  output parsed_op_t                 out_opcode,
  output logic [ADDRESS_WIDTH-1:0]   out_address,
  output int_t                       out_time_in,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     occupancy
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    parsed_op_t               opcode;
    logic [ADDRESS_WIDTH-1:0] address;
    int_t                     time_in;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [PW-1:0]   rd_idx;
  logic [CW-1:0]   count;
  int_t            time_nxt;
  logic            accept;
  logic            push;
  logic            pop;

  assign queue_full = (count == CW'(DEPTH));
  assign out_valid  = (count != '0);
  assign occupancy  = count;
  assign accept     = in.op_ready_s && !queue_full && (queue_time >= in.time_cpu);
  assign push       = accept && (in.opcode != NOP);
  assign pop        = out_valid && out_ready;

  // When empty, point at the most recently popped slot so the outputs hold steady.
  assign rd_idx      = out_valid ? head : head - PW'(1);
  assign out_opcode  = mem[rd_idx].opcode;
  assign out_address = mem[rd_idx].address;
  assign out_time_in = mem[rd_idx].time_in;

  always_comb begin
    time_nxt = queue_time + 32'd1;
`ifdef REQUEST_QUEUE_TIME_SKIP_EN
    if ((count == '0) && in.op_ready_s && (in.time_cpu > queue_time + 32'd1))
      time_nxt = in.time_cpu;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      queue_time      <= '0;
      count           <= '0;
      head            <= '0;
      tail            <= '0;
      pending_request <= 1'b0;
    end else begin
      queue_time      <= time_nxt;
      pending_request <= in.op_ready_s && !accept;
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= '{opcode: in.opcode, address: in.address, time_in: queue_time};
  end
endmodule

// File: tb/tb_request_queue.sv
// Self-checking bench for request_queue: directed scenarios plus randomized traffic vs a queue model.
module tb_request_queue;
  import global_defs::*;
  localparam int DEPTH = 16;
  localparam int CW = $clog2(DEPTH) + 1;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  parser_out_struct_t       in_s = '0;
  int_t                     queue_time;
  logic                     queue_full, pending_request, out_valid, out_ready = 1'b0;
  parsed_op_t               out_opcode;
  logic [ADDRESS_WIDTH-1:0] out_address;
  int_t                     out_time_in;
  logic [CW-1:0]            occupancy;

  request_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in(in_s), .queue_time(queue_time), .queue_full(queue_full),
    .pending_request(pending_request), .out_valid(out_valid), .out_opcode(out_opcode),
    .out_address(out_address), .out_time_in(out_time_in), .out_ready(out_ready),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    parsed_op_t               op;
    logic [ADDRESS_WIDTH-1:0] addr;
    int_t                     tin;
  } ent_t;

  ent_t mq[$];
  int_t m_time = 0;
  logic m_pend = 1'b0;
  logic m_acc  = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Advance one clock and update the reference model from the inputs seen at that edge.
  task automatic tick();
    logic acc, pop_m;
    int_t nt;
    ent_t e;
    acc   = in_s.op_ready_s && (mq.size() < DEPTH) && (m_time >= in_s.time_cpu);
    pop_m = (mq.size() != 0) && out_ready;
    nt    = m_time + 32'd1;
`ifdef REQUEST_QUEUE_TIME_SKIP_EN
    if (mq.size() == 0 && in_s.op_ready_s && in_s.time_cpu > m_time + 32'd1) nt = in_s.time_cpu;
`endif
    e.op = in_s.opcode; e.addr = in_s.address; e.tin = m_time;
    @(posedge clk);
    if (pop_m) void'(mq.pop_front());
    if (acc && in_s.opcode != NOP) mq.push_back(e);
    m_pend = in_s.op_ready_s && !acc;
    m_acc  = acc;
    m_time = nt;
    #1;
  endtask

  task automatic new_op();
    in_s.opcode  = ($urandom_range(1, 0) != 0) ? READ : WRITE;
    in_s.address = {2'($urandom_range(3, 0)), $urandom};
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_s = '0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    mq.delete();
    m_time = 0; m_pend = 1'b0; m_acc = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    in_s.op_ready_s = 1'b0;
    out_ready = 1'b1;
    while (mq.size() != 0 && guard < DEPTH + 4) begin
      n_tests++;
      if ({out_opcode, out_address, out_time_in} !== {mq[0].op, mq[0].addr, mq[0].tin}) begin
        n_fail++;
        $display("FAIL drain_head: got op=%0d addr=%0h tin=%0d expected op=%0d addr=%0h tin=%0d",
                 out_opcode, out_address, out_time_in, mq[0].op, mq[0].addr, mq[0].tin);
      end
      tick();
      guard++;
    end
    out_ready = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0 || mq.size() != 0) begin
      n_fail++;
      $display("FAIL drain_empty: got out_valid=%0b model_size=%0d expected 0/0", out_valid, mq.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if (queue_time !== 32'd0 || occupancy !== '0) begin
      n_fail++;
      $display("FAIL reset_count: got time=%0d occ=%0d expected 0/0", queue_time, occupancy);
    end
    n_tests++;
    if ({queue_full, pending_request, out_valid} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 000", {queue_full, pending_request, out_valid});
    end
  endtask

  task automatic test_delayed_accept();
    int   n = 0;
    int_t t_acc = 0;
    in_s = '{opcode: READ, address: 34'h1_0000_0040, time_cpu: 32'd5, op_ready_s: 1'b1};
    out_ready = 1'b0;
    do begin
      t_acc = queue_time;
      tick();
      n++;
      n_tests++;
      if (pending_request !== m_pend || (!m_acc && out_valid !== 1'b0)) begin
        n_fail++;
        $display("FAIL wait_pending: cycle %0d got pend=%0b valid=%0b expected pend=%0b valid=0",
                 n, pending_request, out_valid, m_pend);
      end
    end while (!m_acc && n < 20);
    in_s.op_ready_s = 1'b0;
    n_tests++;
    if (t_acc !== 32'd5 || !m_acc) begin
      n_fail++;
      $display("FAIL accept_time: got %0d expected 5", t_acc);
    end
    n_tests++;
`ifdef REQUEST_QUEUE_TIME_SKIP_EN
    if (n != 2) begin n_fail++; $display("FAIL accept_latency: got %0d cycles expected 2", n); end
`else
    if (n != 6) begin n_fail++; $display("FAIL accept_latency: got %0d cycles expected 6", n); end
`endif
    n_tests++;
    if ({out_valid, out_opcode, out_address, out_time_in, pending_request} !==
        {1'b1, READ, 34'h1_0000_0040, 32'd5, 1'b0}) begin
      n_fail++;
      $display("FAIL head_entry: got v=%0b op=%0d addr=%0h tin=%0d pend=%0b expected 1/1/100000040/5/0",
               out_valid, out_opcode, out_address, out_time_in, pending_request);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0 || out_address !== 34'h1_0000_0040) begin
      n_fail++;
      $display("FAIL hold_after_pop: got v=%0b addr=%0h expected 0/100000040", out_valid, out_address);
    end
  endtask

  task automatic test_full();
    int guard = 0;
    in_s.time_cpu = 0;
    in_s.op_ready_s = 1'b1;
    out_ready = 1'b0;
    new_op();
    while (mq.size() < DEPTH && guard < 40) begin
      tick();
      if (m_acc) new_op();
      guard++;
    end
    n_tests++;
    if (occupancy !== CW'(DEPTH) || queue_full !== 1'b1) begin
      n_fail++;
      $display("FAIL fill: got occ=%0d full=%0b expected %0d/1", occupancy, queue_full, DEPTH);
    end
    tick();
    tick();
    n_tests++;
    if (pending_request !== 1'b1 || occupancy !== CW'(DEPTH)) begin
      n_fail++;
      $display("FAIL overflow_held: got pend=%0b occ=%0d expected 1/%0d", pending_request, occupancy, DEPTH);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_tests++;
    if (queue_full !== 1'b0 || occupancy !== CW'(DEPTH - 1) || pending_request !== 1'b1) begin
      n_fail++;
      $display("FAIL no_bypass: got full=%0b occ=%0d pend=%0b expected 0/%0d/1",
               queue_full, occupancy, pending_request, DEPTH - 1);
    end
    tick();
    n_tests++;
    if (occupancy !== CW'(DEPTH) || pending_request !== 1'b0) begin
      n_fail++;
      $display("FAIL refill: got occ=%0d pend=%0b expected %0d/0", occupancy, pending_request, DEPTH);
    end
    drain();
  endtask

  task automatic test_wrap();
    int guard = 0;
    in_s.time_cpu = 0;
    in_s.op_ready_s = 1'b1;
    out_ready = 1'b0;
    new_op();
    while (mq.size() < 3 && guard < 10) begin
      tick();
      if (m_acc) new_op();
      guard++;
    end
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (m_acc) new_op();
      n_tests++;
      if (occupancy !== CW'(3) || mq.size() != 3 || out_address !== mq[0].addr || out_opcode !== mq[0].op) begin
        n_fail++;
        $display("FAIL wrap_pair %0d: got occ=%0d addr=%0h expected 3 addr=%0h",
                 i, occupancy, out_address, mq[0].addr);
      end
    end
    drain();
  endtask

  task automatic test_nop();
    int   n = 0;
    int_t t_acc = 0;
    do_reset();
    in_s = '{opcode: NOP, address: 34'h0_1234_5678, time_cpu: 32'd2, op_ready_s: 1'b1};
    do begin
      t_acc = queue_time;
      tick();
      n++;
      n_tests++;
      if (occupancy !== '0 || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL nop_stored: got occ=%0d valid=%0b expected 0/0", occupancy, out_valid);
      end
    end while (!m_acc && n < 10);
    in_s.op_ready_s = 1'b0;
    n_tests++;
    if (t_acc !== 32'd2 || !m_acc) begin
      n_fail++;
      $display("FAIL nop_time: got %0d expected 2", t_acc);
    end
    tick();
    n_tests++;
    if (pending_request !== 1'b0 || occupancy !== '0) begin
      n_fail++;
      $display("FAIL nop_after: got pend=%0b occ=%0d expected 0/0", pending_request, occupancy);
    end
  endtask

  task automatic test_time_skip();
    int n = 0;
    do_reset();
    in_s = '{opcode: WRITE, address: 34'h2_0000_1000, time_cpu: 32'd1000, op_ready_s: 1'b1};
    do begin
      tick();
      n++;
    end while (!m_acc && n < 1100);
    in_s.op_ready_s = 1'b0;
    n_tests++;
`ifdef REQUEST_QUEUE_TIME_SKIP_EN
    if (n != 2) begin n_fail++; $display("FAIL skip_latency: got %0d cycles expected 2", n); end
`else
    if (n != 1001) begin n_fail++; $display("FAIL skip_latency: got %0d cycles expected 1001", n); end
`endif
    n_tests++;
    if (out_valid !== 1'b1 || out_time_in !== 32'd1000 || queue_time !== 32'd1001) begin
      n_fail++;
      $display("FAIL skip_entry: got v=%0b tin=%0d time=%0d expected 1/1000/1001",
               out_valid, out_time_in, queue_time);
    end
  endtask

  task automatic test_async_reset();
    int guard = 0;
    do_reset();
    in_s.time_cpu = 0;
    in_s.op_ready_s = 1'b1;
    new_op();
    while (mq.size() < 7 && guard < 20) begin
      tick();
      if (m_acc) new_op();
      guard++;
    end
    in_s.op_ready_s = 1'b0;
    n_tests++;
    if (occupancy !== CW'(7)) begin
      n_fail++;
      $display("FAIL pre_reset_occ: got %0d expected 7", occupancy);
    end
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if ({queue_time, occupancy, out_valid, queue_full, pending_request} !== '0) begin
      n_fail++;
      $display("FAIL async_clear: got time=%0d occ=%0d valid=%0b expected 0/0/0",
               queue_time, occupancy, out_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    mq.delete();
    m_time = 0; m_pend = 1'b0; m_acc = 1'b0;
    tick();
    n_tests++;
    if (queue_time !== 32'd1 || occupancy !== '0) begin
      n_fail++;
      $display("FAIL restart: got time=%0d occ=%0d expected 1/0", queue_time, occupancy);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      in_s.op_ready_s = ($urandom_range(3, 0) != 0);
      case ($urandom_range(2, 0))
        0:       in_s.opcode = NOP;
        1:       in_s.opcode = READ;
        default: in_s.opcode = WRITE;
      endcase
      in_s.address  = {2'($urandom_range(3, 0)), $urandom};
      in_s.time_cpu = (m_time < 2) ? int_t'($urandom_range(2, 0)) : m_time + int_t'($urandom_range(4, 0)) - 32'd2;
      out_ready = (i < 200) ? ($urandom_range(3, 0) == 0) : ($urandom_range(3, 0) != 0);
      tick();
      n_tests++;
      if ({queue_time, occupancy, queue_full, pending_request, out_valid} !==
          {m_time, CW'(mq.size()), mq.size() == DEPTH, m_pend, mq.size() != 0}) begin
        n_fail++;
        $display("FAIL rand_ctrl %0d: got time=%0d occ=%0d full=%0b pend=%0b expected time=%0d occ=%0d pend=%0b",
                 i, queue_time, occupancy, queue_full, pending_request, m_time, mq.size(), m_pend);
      end
      if (mq.size() != 0) begin
        n_tests++;
        if ({out_opcode, out_address, out_time_in} !== {mq[0].op, mq[0].addr, mq[0].tin}) begin
          n_fail++;
          $display("FAIL rand_head %0d: got op=%0d addr=%0h tin=%0d expected op=%0d addr=%0h tin=%0d",
                   i, out_opcode, out_address, out_time_in, mq[0].op, mq[0].addr, mq[0].tin);
        end
      end
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_delayed_accept();
    test_full();
    test_wrap();
    test_nop();
    test_time_skip();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
